// File: rtl/debug_dump_tx.sv
// rtl/debug_dump_tx.sv - walks a word-addressed debug source and streams it MSB-first as framed bytes to the UART TX FIFO.
// Optional trailing XOR checksum byte is built when DEBUG_DUMP_CHECKSUM_EN is defined.
module debug_dump_tx #(
  parameter int          NUM_WORDS   = 32,
  parameter int          ADDR_W      = 5,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_START,
  input  logic [31:0]       I_WORD_DATA,
  input  logic              I_TX_FULL,
  output logic [ADDR_W-1:0] O_WORD_ADDR,
  output logic              O_WR_UART,
  output logic [7:0]        O_TX_DATA,
  output logic              O_BUSY,
  output logic              O_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_LOAD,
    S_SEND,
`ifdef DEBUG_DUMP_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0]        cks_q, cks_d;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    cks_d     = cks_q;
`endif
    O_WR_UART = 1'b0;
    O_DONE    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_HEADER;
          busy_d  = 1'b1;
          addr_d  = '0;
          tx_d    = HEADER_BYTE;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      S_HEADER: begin
        O_WR_UART = !I_TX_FULL;
        if (!I_TX_FULL) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = I_WORD_DATA;
        tx_d    = I_WORD_DATA[31:24];
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        O_WR_UART = !I_TX_FULL;
        if (!I_TX_FULL) begin
          // tx_q mirrors shift_q[31:24]; the next byte sits just below it
          cnt_d   = cnt_q + 2'd1;
          shift_d = shift_q << 8;
          tx_d    = shift_q[23:16];
`ifdef DEBUG_DUMP_CHECKSUM_EN
          cks_d   = cks_q ^ tx_q;
`endif
          if (cnt_q == 2'd3) begin
            if (addr_q == LAST_ADDR) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
              state_d = S_CKSUM;
              tx_d    = cks_q ^ tx_q;
`else
              state_d = S_DONE;
`endif
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      S_CKSUM: begin
        O_WR_UART = !I_TX_FULL;
        if (!I_TX_FULL) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        O_DONE  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign O_WORD_ADDR = addr_q;
  assign O_TX_DATA   = tx_q;
  assign O_BUSY      = busy_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb/tb_debug_dump_tx.sv - self-checking bench for debug_dump_tx (2-word and 32-word instances).
module tb_debug_dump_tx;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start2, full2, start32, full32;
  logic [31:0] rd2, rd32;
  logic [0:0]  addr2;
  logic [4:0]  addr32;
  logic        wr2, busy2, done2, wr32, busy32, done32;
  logic [7:0]  tx2, tx32;
  logic [31:0] mem2 [0:1];

  debug_dump_tx #(.NUM_WORDS(2), .ADDR_W(1), .HEADER_BYTE(8'hA5)) dut2 (
    .CLK(clk), .RESET(rst), .I_START(start2), .I_WORD_DATA(rd2), .I_TX_FULL(full2),
    .O_WORD_ADDR(addr2), .O_WR_UART(wr2), .O_TX_DATA(tx2), .O_BUSY(busy2), .O_DONE(done2)
  );

  debug_dump_tx #(.NUM_WORDS(32), .ADDR_W(5), .HEADER_BYTE(8'hA5)) dut32 (
    .CLK(clk), .RESET(rst), .I_START(start32), .I_WORD_DATA(rd32), .I_TX_FULL(full32),
    .O_WORD_ADDR(addr32), .O_WR_UART(wr32), .O_TX_DATA(tx32), .O_BUSY(busy32), .O_DONE(done32)
  );

  // Debug source with one cycle of read latency
  always @(posedge clk) begin
    rd2  <= mem2[addr2];
    rd32 <= {27'd0, addr32};
  end

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          mode;   // 0 free, 1 stall on 0x56, 2 random full, 3 start glitches
    logic [7:0]  cks;
    int          cycles; // START edge to DONE cycle without checksum
  } vec_t;

  vec_t vecs [5];
  logic [7:0] q2 [$];
  logic [7:0] q32 [$];
  int n_cmp = 0, n_fail = 0;
  int cyc, first_wr, stalls, mode;
  int done_cnt2, done_cyc2, done_cnt32, done_cyc32, wr_cnt32, last_addr32;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    case (mode)
      1: begin
        if (busy2 && tx2 == 8'h56 && stalls < 5 && !done2) begin
          full2 = 1'b1;
          stalls++;
        end else full2 = 1'b0;
      end
      2: full2 = 1'($urandom_range(0, 1));
      3: begin
        full2  = 1'b0;
        start2 = (cyc == 5) || done2;
      end
      default: full2 = 1'b0;
    endcase
    #1;
    cyc++;
    if (mode == 1 && full2) begin
      check("stall_wr", wr2, 0);
      check("stall_data", tx2, 8'h56);
    end
    if (wr2) begin
      if (first_wr < 0) first_wr = cyc;
      if (q2.size() == 0) check("unexpected_wr2", 1, 0);
      else begin
        e = q2.pop_front();
        check("byte2", tx2, e);
      end
    end
    if (wr32) begin
      wr_cnt32++;
      if (q32.size() == 0) check("unexpected_wr32", 1, 0);
      else begin
        e = q32.pop_front();
        check("byte32", tx32, e);
      end
    end
    if (busy32 && 32'(addr32) != last_addr32) begin
      check("addr32_step", addr32, last_addr32 + 1);
      last_addr32 = addr32;
    end
    if (done2) begin
      done_cnt2++;
      done_cyc2 = cyc;
      check("busy2_in_done", busy2, 1);
    end
    if (done32) begin
      done_cnt32++;
      done_cyc32 = cyc;
    end
  endtask

  task automatic push_frame2(input vec_t v);
    q2.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) q2.push_back(v.w0[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) q2.push_back(v.w1[i*8 +: 8]);
    if (CK == 1) q2.push_back(v.cks);
  endtask

  task automatic run_frame2(input vec_t v);
    mem2[0] = v.w0;
    mem2[1] = v.w1;
    mode = v.mode;
    push_frame2(v);
    stalls = 0; done_cnt2 = 0; first_wr = -1; cyc = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 400 && done_cnt2 == 0; i++) step();
    check("done2_seen", done_cnt2, 1);
    if (v.mode != 2) check("first_wr_latency", first_wr, 1);
    if (v.mode == 0 || v.mode == 3) check("frame_cycles", done_cyc2, v.cycles + CK);
    if (v.mode == 1) check("stall_count", stalls, 5);
    step();
    check("busy2_after_done", busy2, 0);
    for (int i = 0; i < 4; i++) step();
    check("done2_single", done_cnt2, 1);
    check("q2_drained", q2.size(), 0);
    mode = 0;
  endtask

  initial begin
    vecs[0] = '{32'h12345678, 32'hDEADBEEF, 0, 8'h2A, 14};
    vecs[1] = '{32'h12345678, 32'hDEADBEEF, 1, 8'h2A, 14};
    vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 2, 8'h00, 14};
    vecs[3] = '{32'hA5A5A5A5, 32'h01020304, 3, 8'h04, 14};
    vecs[4] = '{32'h80000001, 32'h7F00FF10, 0, 8'h11, 14};
    mode = 0; cyc = 0; first_wr = -1; stalls = 0;
    done_cnt2 = 0; done_cyc2 = 0; done_cnt32 = 0; done_cyc32 = 0;
    wr_cnt32 = 0; last_addr32 = 0;
    mem2[0] = '0; mem2[1] = '0;
    rst = 1'b1; start2 = 1'b0; full2 = 1'b0; start32 = 1'b0; full32 = 1'b0;
    step();
    step();
    check("rst_addr2", addr2, 0);
    check("rst_tx2", tx2, 0);
    check("rst_wr2", wr2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_tx32", tx32, 0);
    check("rst_busy32", busy32, 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_frame2(vecs[i]);

    // Abandon a frame after 0x34 with an asynchronous reset
    mem2[0] = vecs[0].w0;
    mem2[1] = vecs[0].w1;
    push_frame2(vecs[0]);
    cyc = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 50 && q2.size() > 6 + CK; i++) step();
    check("reached_0x34", q2.size(), 6 + CK);
    step();
    rst = 1'b1;
    #1;
    check("midrst_addr2", addr2, 0);
    check("midrst_tx2", tx2, 0);
    check("midrst_wr2", wr2, 0);
    check("midrst_busy2", busy2, 0);
    check("midrst_done2", done2, 0);
    q2.delete();
    step();
    step();
    rst = 1'b0;
    run_frame2(vecs[0]);

    // 32-word frame, source word = address
    q32.push_back(8'hA5);
    for (int a = 0; a < 32; a++) begin
      q32.push_back(8'h00); q32.push_back(8'h00); q32.push_back(8'h00);
      q32.push_back(8'(a));
    end
    if (CK == 1) q32.push_back(8'h00);
    last_addr32 = 0; wr_cnt32 = 0; done_cnt32 = 0; cyc = 0;
    start32 = 1'b1;
    step();
    start32 = 1'b0;
    for (int i = 0; i < 1000 && done_cnt32 == 0; i++) step();
    check("done32_seen", done_cnt32, 1);
    check("frame32_cycles", done_cyc32, 194 + CK);
    check("bytes32", wr_cnt32, 129 + CK);
    check("last_addr32", addr32, 31);
    step();
    check("busy32_after_done", busy32, 0);
    check("q32_drained", q32.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_dump_tx.md
Name: debug_dump_tx

Overview:
- Debug read-out transmitter; the outbound counterpart of the instruction loader that packs host words into program memory.
- On request, walks a word-addressed debug source (register file, data memory or program-memory snapshot, selected outside this block).
- Serialises the words into bytes framed for the UART TX FIFO, MSB first, with `wr`/`full` handshake.
- Sits between the MIPS debug outputs (via an external bank mux) and the UART transmitter; started by the top-level FSM after a step or at program finish.

Parameters:
- NUM_WORDS, 32, number of 32-bit words dumped per frame (1..2^ADDR_W).
- ADDR_W, 5, width of word address.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- I_START  input  1  frame request; sampled only in IDLE.
- I_WORD_DATA  input  32  word at O_WORD_ADDR; valid exactly 1 cycle after the address is presented.
- I_TX_FULL  input  1  UART TX FIFO full.
- O_WORD_ADDR  output  ADDR_W  word address to the debug source mux.
- O_WR_UART  output  1  byte write strobe to the TX FIFO.
- O_TX_DATA  output  8  byte to the TX FIFO.
- O_BUSY  output  1  high from START acceptance until the DONE state is exited.
- O_DONE  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset values: state IDLE; O_WORD_ADDR=0, O_TX_DATA=0, O_WR_UART=0, O_BUSY=0, O_DONE=0; shift register, byte counter and checksum cleared.
- States: IDLE, HEADER, FETCH, LOAD, SEND, (CKSUM), DONE.
- IDLE:
  - I_START=1 → HEADER, O_BUSY←1, address←0, O_TX_DATA←HEADER_BYTE.
  - I_START=0 → stay in IDLE.
- Write rule (all sending states): O_WR_UART = (state ∈ {HEADER, SEND, CKSUM}) && !I_TX_FULL, combinational. O_TX_DATA is registered and stable while a write is pending.
  - A byte is consumed only in a cycle where O_WR_UART=1.
  - While I_TX_FULL=1 the state, data and counters hold indefinitely. No byte is ever dropped or duplicated.
- HEADER: on write → FETCH.
- FETCH: O_WORD_ADDR driven with the current address (registered, stable) → LOAD unconditionally.
- LOAD: shift register ← I_WORD_DATA; O_TX_DATA ← I_WORD_DATA[31:24]; byte count←0 → SEND.
- SEND:
  - On each write: byte count+1, shift left by 8, O_TX_DATA ← next MSB byte.
  - After the 4th byte of a word:
    - If address == NUM_WORDS-1 → CKSUM (if the feature is compiled in) else DONE.
    - Otherwise address+1 → FETCH.
- DONE: O_DONE=1 for exactly one cycle, O_BUSY←0 → IDLE. A START arriving in DONE is ignored.
- Latency:
  - START sampled at edge k → first O_WR_UART possible in cycle k+1.
  - Each word costs 2 non-transmitting cycles (FETCH, LOAD) plus 4 write cycles.
  - Frame with no backpressure = 1 + 6·NUM_WORDS + 1 cycles (+1 with checksum).
- I_START while busy: ignored, no restart, no queueing.
- Address never exceeds NUM_WORDS-1; it does not wrap within a frame and restarts at 0 on every frame.
- RESET mid-frame: immediate return to reset values, no further writes; the partial frame is abandoned.
- NUM_WORDS=1 edge: a single word is sent, then CKSUM/DONE.

Optional Feature:
- Macro DEBUG_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR of all payload bytes (header excluded) is accumulated on each SEND write.
  - It is cleared when a frame starts.
  - It is sent as one extra byte in CKSUM (same full-handshake rule) before DONE.
- Undefined: no CKSUM state and no checksum register; frame = header + 4·NUM_WORDS bytes.

Test Plan:
- NUM_WORDS=2, words 0x12345678, 0xDEADBEEF, I_TX_FULL=0, pulse START → writes A5 12 34 56 78 DE AD BE EF (then 2A with checksum), O_DONE one pulse; first write 1 cycle after START; 14 cycles START→DONE without checksum.
- Same frame, I_TX_FULL held high 5 cycles during the byte 0x56 → O_WR_UART low throughout, O_TX_DATA stays 0x56, then the sequence resumes with no loss or duplication.
- I_START pulsed during SEND and again during DONE → no second frame and byte order unchanged; O_BUSY falls only after DONE.
- RESET asserted after byte 0x34 → outputs at reset values within the reset cycle; a new START produces a full frame beginning with A5 and address 0.
- NUM_WORDS=32, source returns word = address → 129 bytes, O_WORD_ADDR steps 0..31 each held through FETCH/LOAD; last payload bytes 00 00 00 1F.
- I_TX_FULL randomly toggled across a full frame → the byte stream captured on O_WR_UART exactly equals the no-backpressure stream.
